// File: rtl/xtea_block_sequencer_if.sv
// Bundle of command, status, memory and core signals around xtea_block_sequencer.
// master = the sequencer itself; slave = controller glue, memories and core.
interface xtea_block_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              cmd_start;
  logic              cmd_decrypt;
  logic              cmd_cbc;
  logic [63:0]       cmd_iv;
  logic [ADDR_W-1:0] key_base;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [CNT_W-1:0]  num_blocks;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  blocks_done;
  logic [ADDR_W-1:0] key_addr;
  logic [7:0]        key_rdata;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_rdata;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_wdata;
  logic              dst_we;
  logic              xt_start;
  logic              xt_decrypt;
  logic [127:0]      xt_key;
  logic [63:0]       xt_data_in;
  logic [63:0]       xt_data_out;
  logic              xt_ready;

  modport master (
    input  cmd_start, cmd_decrypt, cmd_cbc, cmd_iv, key_base, src_base, dst_base, num_blocks,
    output busy, done, blocks_done,
    output key_addr, input key_rdata,
    output src_addr, input src_rdata,
    output dst_addr, dst_wdata, dst_we,
    output xt_start, xt_decrypt, xt_key, xt_data_in,
    input  xt_data_out, xt_ready
  );

  modport slave (
    output cmd_start, cmd_decrypt, cmd_cbc, cmd_iv, key_base, src_base, dst_base, num_blocks,
    input  busy, done, blocks_done,
    input  key_addr, output key_rdata,
    input  src_addr, output src_rdata,
    input  dst_addr, dst_wdata, dst_we,
    input  xt_start, xt_decrypt, xt_key, xt_data_in,
    output xt_data_out, xt_ready
  );
endinterface

// File: rtl/xtea_block_sequencer.sv
// Bulk XTEA job sequencer: key load, per-block read / core kick / write-back.
// Optional CBC chaining is compiled in with XTEA_SEQ_CBC_EN.
module xtea_block_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  xtea_block_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, KEY_RD, DAT_RD, KICK, WAIT, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] key_base_q, key_base_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  blocks_done_q, blocks_done_d;
  logic              decrypt_q, decrypt_d;
  logic [127:0]      key_q, key_d;
  logic [55:0]       blk_q, blk_d;
  logic [63:0]       din_q, din_d;
  logic [63:0]       res_q, res_d;
`ifdef XTEA_SEQ_CBC_EN
  logic              cbc_q, cbc_d;
  logic [63:0]       prev_q, prev_d;
`endif

  // Read data lags the address by one cycle, so byte (cnt-1) lands each cycle.
  logic [3:0] key_idx;
  logic [2:0] dat_idx;
  assign key_idx = cnt_q[3:0] - 4'd1;
  assign dat_idx = cnt_q[2:0] - 3'd1;

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.blocks_done = blocks_done_q;
  assign bus.xt_start    = (state_q == KICK);
  assign bus.xt_decrypt  = decrypt_q;
  assign bus.xt_key      = key_q;
  assign bus.xt_data_in  = din_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_base_d    = key_base_q;
    src_base_d    = src_base_q;
    dst_base_d    = dst_base_q;
    off_d         = off_q;
    num_d         = num_q;
    blocks_done_d = blocks_done_q;
    decrypt_d     = decrypt_q;
    key_d         = key_q;
    blk_d         = blk_q;
    din_d         = din_q;
    res_d         = res_q;
`ifdef XTEA_SEQ_CBC_EN
    cbc_d         = cbc_q;
    prev_d        = prev_q;
`endif
    bus.key_addr  = '0;
    bus.src_addr  = '0;
    bus.dst_addr  = '0;
    bus.dst_wdata = '0;
    bus.dst_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          decrypt_d     = bus.cmd_decrypt;
          key_base_d    = bus.key_base;
          src_base_d    = bus.src_base;
          dst_base_d    = bus.dst_base;
          num_d         = bus.num_blocks;
          blocks_done_d = '0;
          off_d         = '0;
          cnt_d         = '0;
`ifdef XTEA_SEQ_CBC_EN
          cbc_d         = bus.cmd_cbc;
          prev_d        = bus.cmd_iv;
`endif
          state_d       = (bus.num_blocks == '0) ? DONE : KEY_RD;
        end
      end
      KEY_RD: begin
        if (!cnt_q[4]) bus.key_addr = key_base_q + ADDR_W'(cnt_q);
        if (cnt_q != 5'd0) key_d[{key_idx, 3'b000} +: 8] = bus.key_rdata;
        if (cnt_q == 5'd16) begin
          cnt_d   = '0;
          state_d = DAT_RD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DAT_RD: begin
        if (!cnt_q[3]) bus.src_addr = src_base_q + off_q + ADDR_W'(cnt_q);
        if (cnt_q == 5'd8) begin
          din_d = {bus.src_rdata, blk_q};
`ifdef XTEA_SEQ_CBC_EN
          if (cbc_q && !decrypt_q) din_d = {bus.src_rdata, blk_q} ^ prev_q;
`endif
          cnt_d   = '0;
          state_d = KICK;
        end else begin
          if (cnt_q != 5'd0) blk_d[{dat_idx, 3'b000} +: 8] = bus.src_rdata;
          cnt_d = cnt_q + 5'd1;
        end
      end
      KICK: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // First WAIT cycle may still see ready from the previous operation.
        if (cnt_q == 5'd0) begin
          cnt_d = 5'd1;
        end else if (bus.xt_ready) begin
          res_d = bus.xt_data_out;
`ifdef XTEA_SEQ_CBC_EN
          if (cbc_q && decrypt_q) begin
            res_d  = bus.xt_data_out ^ prev_q;
            prev_d = din_q;
          end else if (cbc_q) begin
            prev_d = bus.xt_data_out;
          end
`endif
          cnt_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        bus.dst_we    = 1'b1;
        bus.dst_addr  = dst_base_q + off_q + ADDR_W'(cnt_q);
        bus.dst_wdata = res_q[{cnt_q[2:0], 3'b000} +: 8];
        if (cnt_q == 5'd7) begin
          blocks_done_d = blocks_done_q + 1'b1;
          cnt_d         = '0;
          if (blocks_done_d == num_q) begin
            state_d = DONE;
          end else begin
            off_d   = off_q + ADDR_W'(8);
            state_d = DAT_RD;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_base_q    <= '0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      off_q         <= '0;
      num_q         <= '0;
      blocks_done_q <= '0;
      decrypt_q     <= 1'b0;
      key_q         <= '0;
      blk_q         <= '0;
      din_q         <= '0;
      res_q         <= '0;
`ifdef XTEA_SEQ_CBC_EN
      cbc_q         <= 1'b0;
      prev_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_base_q    <= key_base_d;
      src_base_q    <= src_base_d;
      dst_base_q    <= dst_base_d;
      off_q         <= off_d;
      num_q         <= num_d;
      blocks_done_q <= blocks_done_d;
      decrypt_q     <= decrypt_d;
      key_q         <= key_d;
      blk_q         <= blk_d;
      din_q         <= din_d;
      res_q         <= res_d;
`ifdef XTEA_SEQ_CBC_EN
      cbc_q         <= cbc_d;
      prev_q        <= prev_d;
`endif
    end
  end
endmodule
